// File: rtl/conv_seq_if.sv
// Signal bundle between the conv sequencer (master) and the weight memory / conv engines (slave).
// Optional build macro of the attached controller: CONV_SEQ_CYCLE_CNT_EN (drives cycle_cnt).
interface conv_seq_if #(
    parameter int AW = 8
);
    // Handshake: trigger is a level sampled only while idle; *_start, acc_clr and acc_en
    // are one-cycle pulses; *_done pulses are sampled only in the matching wait state,
    // and w_ld_valid qualifies w_ld_idx/w_ld_layer one cycle after each w_rd_en.
    logic          trigger;
    logic          busy;
    logic          w_rd_en;
    logic [AW-1:0] w_rd_addr;
    logic          w_layer_sel;
    logic          w_ld_valid;
    logic [7:0]    w_ld_idx;
    logic          w_ld_layer;
    logic          conv1_start;
    logic          conv1_done;
    logic          conv2_start;
    logic          conv2_done;
    logic          acc_clr;
    logic          acc_en;
    logic [7:0]    chan_idx;
    logic          out_valid;
    logic [31:0]   cycle_cnt;
    logic [3:0]    state_dbg;

    modport master (
        input  trigger, conv1_done, conv2_done,
        output busy, w_rd_en, w_rd_addr, w_layer_sel, w_ld_valid, w_ld_idx, w_ld_layer,
               conv1_start, conv2_start, acc_clr, acc_en, chan_idx, out_valid,
               cycle_cnt, state_dbg
    );

    modport slave (
        output trigger, conv1_done, conv2_done,
        input  busy, w_rd_en, w_rd_addr, w_layer_sel, w_ld_valid, w_ld_idx, w_ld_layer,
               conv1_start, conv2_start, acc_clr, acc_en, chan_idx, out_valid,
               cycle_cnt, state_dbg
    );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Per-trigger schedule for conv1 -> conv2 -> accumulate over CHAN channels, including weight streaming.
// Optional macro CONV_SEQ_CYCLE_CNT_EN: enables the run-length cycle counter on cycle_cnt.
module conv_seq_ctrl #(
    parameter int K_H  = 3,
    parameter int K_W  = 3,
    parameter int CHAN = 10,
    parameter int AW   = 8
) (
    input  logic       clk,
    input  logic       rst,
    conv_seq_if.master bus
);
    localparam int KK = K_H * K_W;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CLR    = 4'd1,
        S_LOAD1  = 4'd2,
        S_LOAD2  = 4'd3,
        S_START1 = 4'd4,
        S_WAIT1  = 4'd5,
        S_START2 = 4'd6,
        S_WAIT2  = 4'd7,
        S_ACC    = 4'd8,
        S_NEXT   = 4'd9,
        S_DONE   = 4'd10
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] k_cnt;
    logic [7:0] chan_idx;
    logic       out_valid;
    logic       k_last;
    logic       chan_last;
    logic       accept;

    logic       busy_c;
    logic       rd_en_c;
    logic       sel_c;
    logic       c1_start_c;
    logic       c2_start_c;
    logic       clr_c;
    logic       acc_c;

    logic       ld_valid_q;
    logic [7:0] ld_idx_q;
    logic       ld_layer_q;

    assign k_last    = (k_cnt == 8'(KK - 1));
    assign chan_last = (chan_idx == 8'(CHAN - 1));
    assign accept    = (state == S_IDLE) && bus.trigger;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy_c     = 1'b1;
        rd_en_c    = 1'b0;
        sel_c      = 1'b0;
        c1_start_c = 1'b0;
        c2_start_c = 1'b0;
        clr_c      = 1'b0;
        acc_c      = 1'b0;
        case (state)
            S_IDLE: begin
                busy_c = 1'b0;
                if (bus.trigger) state_nxt = S_CLR;
            end
            S_CLR: begin
                clr_c     = 1'b1;
                state_nxt = S_LOAD1;
            end
            S_LOAD1: begin
                rd_en_c = 1'b1;
                if (k_last) state_nxt = S_LOAD2;
            end
            S_LOAD2: begin
                rd_en_c = 1'b1;
                sel_c   = 1'b1;
                if (k_last) state_nxt = S_START1;
            end
            S_START1: begin
                c1_start_c = 1'b1;
                state_nxt  = S_WAIT1;
            end
            S_WAIT1:  if (bus.conv1_done) state_nxt = S_START2;
            S_START2: begin
                c2_start_c = 1'b1;
                state_nxt  = S_WAIT2;
            end
            S_WAIT2:  if (bus.conv2_done) state_nxt = S_ACC;
            S_ACC: begin
                acc_c     = 1'b1;
                state_nxt = S_NEXT;
            end
            S_NEXT:   state_nxt = chan_last ? S_DONE : S_LOAD1;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // k restarts at 0 for each bank, so LOAD2 reuses the same channel base address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_cnt <= '0;
        end else if (state == S_LOAD1 || state == S_LOAD2) begin
            k_cnt <= k_last ? 8'd0 : k_cnt + 8'd1;
        end else begin
            k_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan_idx  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                chan_idx  <= '0;
                out_valid <= 1'b0;
            end else if (state == S_NEXT) begin
                if (chan_last) out_valid <= 1'b1;
                else           chan_idx  <= chan_idx + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_valid_q <= 1'b0;
            ld_idx_q   <= '0;
            ld_layer_q <= 1'b0;
        end else begin
            ld_valid_q <= rd_en_c;
            ld_idx_q   <= k_cnt;
            ld_layer_q <= sel_c;
        end
    end

`ifdef CONV_SEQ_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_q;

    // The DONE cycle itself is counted, so the final value equals the run length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  cycle_cnt_q <= '0;
        else if (accept)          cycle_cnt_q <= '0;
        else if (state != S_IDLE) cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end

    assign bus.cycle_cnt = cycle_cnt_q;
`else
    assign bus.cycle_cnt = 32'd0;
`endif

    assign bus.busy        = busy_c;
    assign bus.w_rd_en     = rd_en_c;
    assign bus.w_layer_sel = sel_c;
    assign bus.w_rd_addr   = AW'(32'(chan_idx) * 32'(KK) + 32'(k_cnt));
    assign bus.w_ld_valid  = ld_valid_q;
    assign bus.w_ld_idx    = ld_idx_q;
    assign bus.w_ld_layer  = ld_layer_q;
    assign bus.conv1_start = c1_start_c;
    assign bus.conv2_start = c2_start_c;
    assign bus.acc_clr     = clr_c;
    assign bus.acc_en      = acc_c;
    assign bus.chan_idx    = chan_idx;
    assign bus.out_valid   = out_valid;
    assign bus.state_dbg   = state;
endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
Sequencer for the two-layer per-channel conv datapath (conv1 -> ReLU -> conv2 -> ReLU -> channel accumulate). It runs the whole schedule once per trigger:
- For each of CHAN channels, streams that channel's conv1 and conv2 kernel weights from the weight memory into the datapath.
- Starts conv1, waits for it, starts conv2, waits for it, then pulses accumulate.
- After the last channel, raises out_valid.

Parameters:
K_H, 3, kernel height
K_W, 3, kernel width
CHAN, 10, number of channels accumulated into the output buffer
AW, 8, weight memory address width; must satisfy 2^AW >= CHAN*K_H*K_W

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
trigger  in  1  start request; sampled only in IDLE
busy  out  1  high from the cycle after trigger is accepted until IDLE is re-entered
w_rd_en  out  1  weight memory read strobe
w_rd_addr  out  AW  read address = chan_idx*K_H*K_W + k
w_layer_sel  out  1  0 = conv1 weight bank, 1 = conv2 bank
w_ld_valid  out  1  read data valid; w_rd_en delayed one cycle
w_ld_idx  out  8  kernel index k of the data on the bus; w_rd_addr offset delayed one cycle
w_ld_layer  out  1  w_layer_sel delayed one cycle
conv1_start  out  1  one-cycle start pulse to the conv1 engine
conv1_done  in  1  conv1 completion pulse
conv2_start  out  1  one-cycle start pulse to the conv2 engine
conv2_done  in  1  conv2 completion pulse
acc_clr  out  1  one-cycle clear of the output accumulator
acc_en  out  1  one-cycle accumulate of conv2 ReLU output into out_buff
chan_idx  out  8  current channel
out_valid  out  1  level; out_buff final
cycle_cnt  out  32  see Optional Feature

Behaviour:
- Reset (asynchronous, any state): state=IDLE; chan_idx=0, out_valid=0, cycle_cnt=0; every strobe, busy, and the w_ld_* pipeline = 0.
- All strobes are Moore decodes of the registered state. The w_ld_* outputs are registers.
- States and transitions:
  - IDLE: on trigger -> CLR. out_valid clears on that same edge.
  - CLR (1 cycle): acc_clr=1, chan_idx=0 -> LOAD1.
  - LOAD1 (K_H*K_W cycles): w_rd_en=1, w_layer_sel=0, k=0..K_H*K_W-1 -> LOAD2.
  - LOAD2 (K_H*K_W cycles): same as LOAD1 with w_layer_sel=1 -> START1.
  - START1 (1 cycle): conv1_start=1 -> WAIT1.
  - WAIT1: stay until conv1_done=1 -> START2.
  - START2 (1 cycle): conv2_start=1 -> WAIT2.
  - WAIT2: stay until conv2_done=1 -> ACC.
  - ACC (1 cycle): acc_en=1 -> NEXT.
  - NEXT (1 cycle): if chan_idx==CHAN-1 -> DONE; else chan_idx+1 and -> LOAD1.
  - DONE (1 cycle): out_valid set to 1 on entry edge -> IDLE.
- busy=1 in every state except IDLE.
- Last weight read: data arrives (w_ld_valid) in the START1 cycle. Engines must latch weights no later than that edge.
- Done handling: conv1_done and conv2_done are ignored outside WAIT1 and WAIT2 respectively. A done asserted in the start cycle itself is lost; engines must respond >=1 cycle after start.
- trigger outside IDLE is ignored; no queuing.
- Timing (engine done D cycles after start, i.e. first sampled in cycle start+D): channel period = 2*K_H*K_W + 2*D + 4 cycles.
- Reset mid-run: immediate return to IDLE. No acc_en is issued, out_valid=0.

Optional Feature:
CONV_SEQ_CYCLE_CNT_EN
- Defined: cycle_cnt clears on trigger acceptance and increments every cycle while busy=1. It freezes at its final value when DONE is left and holds until the next accepted trigger.
- Undefined: cycle_cnt is tied to 0 and no counter is synthesized. The port stays so the port list is stable.

Test Plan:
- Defaults, engines return done 5 cycles after start, trigger accepted at edge 0:
  - acc_clr in cycle 1.
  - conv1_start in cycles 20+32n, n=0..9.
  - acc_en asserted exactly 10 times.
  - out_valid rises entering cycle 322; with the macro, cycle_cnt=322.
- Weight addressing at channel 3: w_rd_addr 27..35 with sel=0, then 27..35 with sel=1. w_ld_valid/idx/layer trail by one cycle.
- Spurious conv2_done during WAIT1 and a conv1_done pulse during LOAD2 -> no state change; schedule identical to the nominal run.
- trigger pulsed while busy (cycle 50) -> ignored. A trigger after DONE clears out_valid next edge and restarts with chan_idx=0.
- rst asserted during WAIT2 of channel 4 -> asynchronously all outputs 0, state IDLE; the next trigger runs a full clean 10-channel schedule.
- CHAN=1, D=1 -> conv1_start cycle 20, conv2_start 22, acc_en 24, out_valid rises entering cycle 26.
